ps2_kbd_ctrl: RTL and testbench

PS2_KBD_CTRL -- requirements
Module: ps2_kbd_ctrl

---
 rtl/ps2_pkg.sv | 11 +
 rtl/ps2_fifo.sv | 46 ++++
 rtl/ps2_kbd_ctrl.sv | 91 +++++++++
 tb/tb_ps2_kbd_ctrl.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// ps2_pkg: port map, register bit positions and FSM states of the PS/2 keyboard controller
package ps2_pkg;
    localparam logic [11:0] PORT_DATA = 12'h060;
    localparam logic [11:0] PORT_CTRL = 12'h061;
    localparam logic [11:0] PORT_STAT = 12'h064;
    localparam int STAT_OBF = 0;
    localparam int STAT_OVF = 4;
    localparam int CTRL_ACK = 7;
    localparam int CTRL_CLKEN = 6;
    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_FULL, S_HOLD} state_e;
endpackage

// File: rtl/ps2_fifo.sv
// ps2_fifo: synchronous scancode FIFO; a push on a full FIFO is taken only when a pop frees a slot
module ps2_fifo #(
    parameter int DEPTH = 8
) (
    input  logic                     iClk,
    input  logic                     iRstN,
    input  logic                     push,
    input  logic [7:0]               push_data,
    input  logic                     pop,
    input  logic                     flush,
    output logic [7:0]               head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    logic [7:0] mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0] cnt_q, cnt_d;
    logic do_push, do_pop;
    always_comb begin
        do_pop = pop && !empty;
        do_push = push && (!full || do_pop);
        wr_ptr_d = flush ? '0 : wr_ptr_q + AW'(do_push);
        rd_ptr_d = flush ? '0 : rd_ptr_q + AW'(do_pop);
        cnt_d = flush ? '0 : cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
    always_ff @(posedge iClk or negedge iRstN) begin
        if (!iRstN) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q <= cnt_d;
        end
    end
    always_ff @(posedge iClk) begin
        if (do_push && !flush) mem_q[wr_ptr_q] <= push_data;
    end
    assign head = mem_q[rd_ptr_q];
    assign full = cnt_q == (AW+1)'(DEPTH);
    assign empty = cnt_q == '0;
    assign count = cnt_q;
endmodule

// File: rtl/ps2_kbd_ctrl.sv
// ps2_kbd_ctrl: 8042-style keyboard port: scancode FIFO, 60h/64h read ports, 61h ack/clock-inhibit snoop
module ps2_kbd_ctrl import ps2_pkg::*; #(
    parameter int DEPTH = 8,
    parameter bit AUTO_ACK = 1'b0
) (
    input  logic        iClk,
    input  logic        iRstN,
    input  logic [19:0] iAddr,
    input  logic        iRd,
    input  logic        iWr,
    input  logic [7:0]  iWrData,
    input  logic [7:0]  iRxData,
    input  logic        iRxValid,
    output logic        oSel,
    output logic [7:0]  oData,
    output logic        oIrq,
    output logic        oPs2ClkLow
);
    state_e state_q, state_d;
    logic [7:0] out_q, out_d, data_q, data_d, fifo_head;
    logic obf_q, obf_d, ovf_q, ovf_d, sel_q, sel_d, clk_low_q, clk_low_d, run_q;
    logic wr_ctrl, rd_data, rd_stat, flush, ack, pop, push, drop, fifo_full, fifo_empty;
    logic [$clog2(DEPTH):0] fifo_cnt;
    logic unused_bits;
    assign unused_bits = ^{iAddr[19:12], iWrData[5:0], fifo_cnt};
    ps2_fifo #(.DEPTH(DEPTH)) u_fifo (
        .iClk(iClk), .iRstN(iRstN), .push(push), .push_data(iRxData), .pop(pop), .flush(flush),
        .head(fifo_head), .full(fifo_full), .empty(fifo_empty), .count(fifo_cnt)
    );
    always_comb begin
        wr_ctrl = iWr && iAddr[11:0] == PORT_CTRL;
        rd_data = iRd && iAddr[11:0] == PORT_DATA;
        rd_stat = iRd && iAddr[11:0] == PORT_STAT;
        flush = wr_ctrl && !iWrData[CTRL_CLKEN];
        ack = wr_ctrl && iWrData[CTRL_ACK];
        pop = state_q == S_LOAD && !flush;
        push = iRxValid && !clk_low_q && !flush;
        drop = push && fifo_full && !pop;
        out_d = pop ? fifo_head : out_q;
        state_d = state_q;
        obf_d = obf_q;
        if (flush) begin
            state_d = ack ? S_HOLD : S_IDLE;
            obf_d = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: state_d = ack ? S_HOLD : (fifo_empty ? S_IDLE : S_LOAD);
                S_LOAD: begin
                    state_d = ack ? S_HOLD : S_FULL;
                    obf_d = !ack;
                end
                S_FULL: if (ack || (AUTO_ACK && rd_data)) begin
                    state_d = ack ? S_HOLD : S_IDLE;
                    obf_d = 1'b0;
                end
                S_HOLD: state_d = (wr_ctrl && !iWrData[CTRL_ACK]) ? S_IDLE : S_HOLD;
                default: state_d = S_IDLE;
            endcase
        end
        // a drop in the same cycle as a status read must survive to the next read
        ovf_d = flush ? 1'b0 : drop ? 1'b1 : rd_stat ? 1'b0 : ovf_q;
        sel_d = rd_data || rd_stat;
        data_d = rd_data ? out_q : rd_stat ? ((8'(ovf_q) << STAT_OVF) | (8'(obf_q) << STAT_OBF)) : 8'h00;
        clk_low_d = wr_ctrl ? !iWrData[CTRL_CLKEN] : clk_low_q && run_q;
    end
    always_ff @(posedge iClk or negedge iRstN) begin
        if (!iRstN) begin
            state_q <= S_IDLE;
            out_q <= '0;
            data_q <= '0;
            obf_q <= 1'b0;
            ovf_q <= 1'b0;
            sel_q <= 1'b0;
            clk_low_q <= 1'b1;
            run_q <= 1'b0;
        end else begin
            state_q <= state_d;
            out_q <= out_d;
            data_q <= data_d;
            obf_q <= obf_d;
            ovf_q <= ovf_d;
            sel_q <= sel_d;
            clk_low_q <= clk_low_d;
            run_q <= 1'b1;
        end
    end
    assign oSel = sel_q;
    assign oData = data_q;
    assign oIrq = obf_q;
    assign oPs2ClkLow = clk_low_q;
endmodule

// File: tb/tb_ps2_kbd_ctrl.sv
// tb_ps2_kbd_ctrl: two configurations driven in lockstep and compared each cycle with a queue-based model
module tb_ps2_kbd_ctrl;
    localparam int D0 = 8;
    localparam int D1 = 4;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [19:0] addr = '0;
    logic rd = 1'b0, wr = 1'b0, rxv = 1'b0;
    logic [7:0] wdata = '0, rxd = '0;
    logic sel0, irq0, ckl0, sel1, irq1, ckl1;
    logic [7:0] dat0, dat1;
    logic [7:0] mq [2][$];
    logic [7:0] m_out [2];
    logic [7:0] m_dat [2];
    bit m_obf [2], m_ovf [2], m_hold [2], m_load [2], m_sel [2], m_ckl [2], m_run [2];
    int n_chk = 0, n_bad = 0;
    int op;
    logic [7:0] v;
    logic [11:0] ports [5] = '{12'h060, 12'h061, 12'h064, 12'h065, 12'h160};
    always #5 clk = ~clk;
    ps2_kbd_ctrl #(.DEPTH(D0), .AUTO_ACK(1'b0)) dut0 (
        .iClk(clk), .iRstN(rst_n), .iAddr(addr), .iRd(rd), .iWr(wr), .iWrData(wdata),
        .iRxData(rxd), .iRxValid(rxv), .oSel(sel0), .oData(dat0), .oIrq(irq0), .oPs2ClkLow(ckl0)
    );
    ps2_kbd_ctrl #(.DEPTH(D1), .AUTO_ACK(1'b1)) dut1 (
        .iClk(clk), .iRstN(rst_n), .iAddr(addr), .iRd(rd), .iWr(wr), .iWrData(wdata),
        .iRxData(rxd), .iRxValid(rxv), .oSel(sel1), .oData(dat1), .oIrq(irq1), .oPs2ClkLow(ckl1)
    );
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask
    task automatic model_reset;
        for (int i = 0; i < 2; i++) begin
            mq[i].delete();
            m_out[i] = 8'h00;
            m_dat[i] = 8'h00;
            {m_obf[i], m_ovf[i], m_hold[i], m_load[i], m_sel[i], m_run[i]} = '0;
            m_ckl[i] = 1'b1;
        end
    endtask
    task automatic model_step(input int i, input int depth, input bit aa);
        bit wr_ctrl, flush, ack, rd60, rd64, pop, take, drop, nonempty;
        wr_ctrl = wr && addr[11:0] == 12'h061;
        flush = wr_ctrl && !wdata[6];
        ack = wr_ctrl && wdata[7];
        rd60 = rd && addr[11:0] == 12'h060;
        rd64 = rd && addr[11:0] == 12'h064;
        m_sel[i] = rd60 || rd64;
        m_dat[i] = rd60 ? m_out[i] : rd64 ? {3'b000, m_ovf[i], 3'b000, m_obf[i]} : 8'h00;
        nonempty = mq[i].size() > 0;
        pop = m_load[i] && !flush;
        take = rxv && !m_ckl[i] && !flush;
        drop = take && mq[i].size() == depth && !pop;
        if (pop) m_out[i] = mq[i].pop_front();
        if (flush) mq[i].delete();
        else if (take && !drop) mq[i].push_back(rxd);
        m_ovf[i] = flush ? 1'b0 : drop ? 1'b1 : rd64 ? 1'b0 : m_ovf[i];
        if (flush) begin
            m_hold[i] = ack;
            m_load[i] = 1'b0;
            m_obf[i] = 1'b0;
        end else if (m_load[i]) begin
            m_load[i] = 1'b0;
            m_hold[i] = ack;
            m_obf[i] = !ack;
        end else if (m_obf[i]) begin
            if (ack || (aa && rd60)) begin
                m_obf[i] = 1'b0;
                m_hold[i] = ack;
            end
        end else if (m_hold[i]) m_hold[i] = !(wr_ctrl && !wdata[7]);
        else if (ack) m_hold[i] = 1'b1;
        else m_load[i] = nonempty;
        m_ckl[i] = wr_ctrl ? !wdata[6] : m_ckl[i] && m_run[i];
        m_run[i] = 1'b1;
    endtask
    task automatic compare_all;
        chk("sel0", sel0, m_sel[0]);
        chk("data0", dat0, m_dat[0]);
        chk("irq0", irq0, m_obf[0]);
        chk("clklow0", ckl0, m_ckl[0]);
        chk("sel1", sel1, m_sel[1]);
        chk("data1", dat1, m_dat[1]);
        chk("irq1", irq1, m_obf[1]);
        chk("clklow1", ckl1, m_ckl[1]);
    endtask
    task automatic cyc(input bit r, input bit w, input logic [11:0] a, input logic [7:0] wd, input bit rv, input logic [7:0] d);
        rd = r;
        wr = w;
        addr = {8'($urandom), a};
        wdata = wd;
        rxv = rv;
        rxd = d;
        model_step(0, D0, 1'b0);
        model_step(1, D1, 1'b1);
        @(posedge clk);
        #1;
        compare_all();
        rd = 1'b0;
        wr = 1'b0;
        rxv = 1'b0;
    endtask
    task automatic push(input logic [7:0] b);
        cyc(1'b0, 1'b0, 12'h000, 8'h00, 1'b1, b);
    endtask
    task automatic idle(input int n);
        for (int k = 0; k < n; k++) cyc(1'b0, 1'b0, 12'h000, 8'h00, 1'b0, 8'h00);
    endtask
    task automatic rd_port(input logic [11:0] a);
        cyc(1'b1, 1'b0, a, 8'h00, 1'b0, 8'h00);
    endtask
    task automatic wr61(input logic [7:0] d);
        cyc(1'b0, 1'b1, 12'h061, d, 1'b0, 8'h00);
    endtask
    initial begin
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        compare_all();
        chk("rst_clklow", ckl0, 1'b1);
        chk("rst_data", dat0, 8'h00);
        rst_n = 1'b1;
        push(8'hAA);
        chk("first_edge_clklow", ckl0, 1'b0);
        idle(3);
        chk("first_edge_no_byte", irq0, 1'b0);
        rd_port(12'h060);
        chk("idle_out_reset", dat0, 8'h00);
        push(8'h1C);
        idle(2);
        chk("load_irq", irq0, 1'b1);
        rd_port(12'h060);
        chk("rd60_data", dat0, 8'h1C);
        chk("rd60_sel", sel0, 1'b1);
        push(8'h32);
        push(8'h21);
        wr61(8'hC0);
        chk("ack_irq", irq0, 1'b0);
        wr61(8'h40);
        idle(2);
        rd_port(12'h060);
        chk("second_byte", dat0, 8'h32);
        wr61(8'hC0);
        wr61(8'h40);
        idle(2);
        rd_port(12'h060);
        chk("third_byte", dat0, 8'h21);
        wr61(8'hC0);
        wr61(8'h40);
        idle(2);
        chk("drained_irq", irq0, 1'b0);
        rd_port(12'h060);
        chk("idle_keeps_out", dat0, 8'h21);
        for (int i = 0; i < D0 + 2; i++) push(8'h40 + 8'(i));
        rd_port(12'h064);
        chk("ovf_status", dat0, 8'h11);
        rd_port(12'h064);
        chk("ovf_cleared", dat0, 8'h01);
        rd_port(12'h060);
        chk("ovf_head", dat0, 8'h40);
        wr61(8'h00);
        wr61(8'h40);
        wr61(8'hC0);
        for (int i = 0; i < D0; i++) push(8'h50 + 8'(i));
        wr61(8'h40);
        idle(1);
        push(8'h5F);
        rd_port(12'h064);
        chk("push_on_pop_no_ovf", dat0, 8'h01);
        wr61(8'h80);
        wr61(8'hC0);
        for (int i = 0; i < 3; i++) push(8'h70 + 8'(i));
        wr61(8'h00);
        chk("inhibit_clklow", ckl0, 1'b1);
        chk("inhibit_irq", irq0, 1'b0);
        push(8'h77);
        wr61(8'h40);
        chk("release_clklow", ckl0, 1'b0);
        idle(3);
        chk("flushed_irq", irq0, 1'b0);
        rd_port(12'h064);
        chk("flushed_status", dat0, 8'h00);
        for (int i = 0; i < 5; i++) push(8'h60 + 8'(i));
        chk("pre_reset_irq", irq0, 1'b1);
        #3 rst_n = 1'b0;
        #1;
        model_reset();
        compare_all();
        chk("async_rst_irq", irq0, 1'b0);
        chk("async_rst_clklow", ckl0, 1'b1);
        @(posedge clk);
        #1 rst_n = 1'b1;
        idle(1);
        rd_port(12'h064);
        chk("post_reset_status", dat0, 8'h00);
        idle(3);
        chk("post_reset_empty", irq0, 1'b0);
        for (int n = 0; n < 3000; n++) begin
            op = $urandom_range(0, 9);
            v = ($urandom_range(0, 15) == 0) ? 8'($urandom) : ($urandom_range(0, 1) == 1 ? 8'hC0 : 8'h40);
            if (op <= 2) cyc(1'b0, 1'b0, 12'h000, 8'h00, $urandom_range(0, 9) < 4, 8'($urandom));
            else if (op <= 4) cyc(1'b1, 1'b0, 12'h060, 8'h00, $urandom_range(0, 9) < 4, 8'($urandom));
            else if (op == 5) cyc(1'b1, 1'b0, 12'h064, 8'h00, $urandom_range(0, 9) < 4, 8'($urandom));
            else if (op <= 7) cyc(1'b0, 1'b1, 12'h061, v, $urandom_range(0, 9) < 4, 8'($urandom));
            else if (op == 8) cyc(1'b1, 1'b0, ports[$urandom_range(0, 4)], 8'h00, 1'b0, 8'h00);
            else cyc(1'b0, 1'b1, ports[$urandom_range(2, 4)], 8'($urandom), 1'b1, 8'($urandom));
        end
        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule
